// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the scan sequencer.
// Optional point skipping is enabled with SCAN_SEQ_SKIP_INVALID_EN.
package scan_seq_pkg;

  localparam int HALF_WIDTH     = 32;
  localparam int POINTS_DEFAULT = 720;
  localparam int SCAN_STRIDE    = POINTS_DEFAULT + 1;

  typedef struct packed {
    logic [HALF_WIDTH-1:0] magnitude;
    logic [HALF_WIDTH-1:0] angle;
  } scan_word_t;

  typedef struct packed {
    logic [HALF_WIDTH-1:0] x;
    logic [HALF_WIDTH-1:0] y;
  } pose_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_POS,
    LATCH_POS,
    FETCH_PT,
    ISSUE,
    WAIT_BEAM,
    SCAN_END,
    PAUSE
  } seq_state_t;

  // One pose word precedes every scan's beam words.
  function automatic int stride_of(input int points);
    return points + 1;
  endfunction

endpackage

// File: rtl/scan_address_gen.sv
// Scan memory address plus scan/point counters for the sequencer.
// Controlled entirely by the sequencer FSM.
module scan_address_gen
  import scan_seq_pkg::*;
#(
  parameter int ADDR_WIDTH      = 13,
  parameter int POINTS_PER_SCAN = 720,
  parameter int SCAN_WIDTH      = 4,
  parameter int POINT_WIDTH     = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   addr_inc,
  input  logic                   point_clear,
  input  logic                   point_inc,
  input  logic                   scan_inc,
  input  logic                   clear,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [SCAN_WIDTH-1:0]  scan_index,
  output logic [POINT_WIDTH-1:0] point_index
);

  localparam logic [ADDR_WIDTH-1:0] STRIDE =
    ADDR_WIDTH'(stride_of(POINTS_PER_SCAN));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      mem_address <= '0;
      scan_index  <= '0;
      point_index <= '0;
    end else begin
      if (load)
        mem_address <= ADDR_WIDTH'(scan_index) * STRIDE;
      else if (addr_inc)
        mem_address <= mem_address + ADDR_WIDTH'(1);
      if (point_clear)
        point_index <= '0;
      else if (point_inc)
        point_index <= point_index + POINT_WIDTH'(1);
      if (scan_inc)
        scan_index <= scan_index + SCAN_WIDTH'(1);
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Walks scan memory, latches poses and feeds beams to the ray-caster.
// Define SCAN_SEQ_SKIP_INVALID_EN to skip invalid points (adds skipped_count).
module scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 13,
  parameter int POINTS_PER_SCAN = 720,
  parameter int NUM_SCANS       = 11,
  parameter int MEM_LATENCY     = 1,
  localparam int H  = DATA_WIDTH / 2,
  localparam int SW = (NUM_SCANS > 1) ? $clog2(NUM_SCANS) : 1,
  localparam int PW = (POINTS_PER_SCAN > 1) ? $clog2(POINTS_PER_SCAN) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  step_mode,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  beam_start,
  output logic [H-1:0]          beam_magnitude,
  output logic [H-1:0]          beam_angle,
  output logic [H-1:0]          sensor_x,
  output logic [H-1:0]          sensor_y,
  input  logic                  beam_busy,
  output logic                  use_bresenham_indices,
  output logic                  busy,
  output logic                  scan_done,
  output logic                  run_done,
  output logic [SW-1:0]         scan_index,
  output logic [PW-1:0]         point_index
`ifdef SCAN_SEQ_SKIP_INVALID_EN
  ,
  output logic [15:0]           skipped_count
`endif
);

  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  seq_state_t state, next;
  logic [LW-1:0] wait_cnt;
  logic [H-1:0] word_hi, word_lo;
  logic wait_done, fetching, last_scan, last_point, skip;
  logic load, addr_inc, point_clear, point_inc;
  logic scan_inc, clear, advance;

  assign word_hi    = mem_data[DATA_WIDTH-1:H];
  assign word_lo    = mem_data[H-1:0];
  assign fetching   = (state == FETCH_POS) || (state == FETCH_PT);
  assign wait_done  = wait_cnt == LW'(MEM_LATENCY - 1);
  assign last_scan  = scan_index == SW'(NUM_SCANS - 1);
  assign last_point = point_index == PW'(POINTS_PER_SCAN - 1);

  assign busy      = state != IDLE;
  assign scan_done = state == SCAN_END;
  assign run_done  = scan_done && last_scan;

`ifdef SCAN_SEQ_SKIP_INVALID_EN
  // Only judged on the first ISSUE cycle, before a request goes out.
  assign skip = !beam_start && (word_hi == '0 || word_hi == '1);

  always_ff @(posedge clock) begin
    if (reset || (state == IDLE && start))
      skipped_count <= '0;
    else if (state == ISSUE && skip && skipped_count != '1)
      skipped_count <= skipped_count + 16'd1;
  end
`else
  assign skip = 1'b0;
`endif

  scan_address_gen #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .POINTS_PER_SCAN(POINTS_PER_SCAN),
    .SCAN_WIDTH     (SW),
    .POINT_WIDTH    (PW)
  ) u_addr (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .addr_inc   (addr_inc),
    .point_clear(point_clear),
    .point_inc  (point_inc),
    .scan_inc   (scan_inc),
    .clear      (clear),
    .mem_address(mem_address),
    .scan_index (scan_index),
    .point_index(point_index)
  );

  always_comb begin
    next        = state;
    load        = 1'b0;
    addr_inc    = 1'b0;
    point_clear = 1'b0;
    point_inc   = 1'b0;
    scan_inc    = 1'b0;
    clear       = 1'b0;
    advance     = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        next = FETCH_POS;
        load = 1'b1;
      end
      FETCH_POS: if (wait_done) next = LATCH_POS;
      LATCH_POS: begin
        next        = FETCH_PT;
        addr_inc    = 1'b1;
        point_clear = 1'b1;
      end
      FETCH_PT: if (wait_done) next = ISSUE;
      ISSUE: begin
        if (skip) advance = 1'b1;
        else if (beam_busy) next = WAIT_BEAM;
      end
      WAIT_BEAM: if (!beam_busy) advance = 1'b1;
      SCAN_END: begin
        if (last_scan) begin
          clear = 1'b1;
          next  = IDLE;
        end else begin
          scan_inc = 1'b1;
          addr_inc = 1'b1;
          next     = step_mode ? PAUSE : FETCH_POS;
        end
      end
      PAUSE: if (start) next = FETCH_POS;
      default: next = IDLE;
    endcase
    if (advance) begin
      if (last_point) begin
        next = SCAN_END;
      end else begin
        point_inc = 1'b1;
        addr_inc  = 1'b1;
        next      = FETCH_PT;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= IDLE;
      wait_cnt              <= '0;
      beam_start            <= 1'b0;
      beam_magnitude        <= '0;
      beam_angle            <= '0;
      sensor_x              <= '0;
      sensor_y              <= '0;
      use_bresenham_indices <= 1'b0;
    end else begin
      state    <= next;
      wait_cnt <= (fetching && next == state) ? wait_cnt + LW'(1) : '0;
      if (state == LATCH_POS) begin
        sensor_x              <= word_hi;
        sensor_y              <= word_lo;
        use_bresenham_indices <= 1'b1;
      end
      if (state == SCAN_END)
        use_bresenham_indices <= 1'b0;
      if (state == ISSUE) begin
        if (!beam_start) begin
          beam_magnitude <= word_hi;
          beam_angle     <= word_lo;
        end
        beam_start <= !beam_busy && !skip;
      end
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized scan runs checked against a scan-level reference model.
// Build with SCAN_SEQ_SKIP_INVALID_EN defined to cover point skipping.
module tb_scan_sequencer;
  import scan_seq_pkg::*;

  localparam int DW = 64, AW = 13, P = 4, N = 2, ML = 1;
  localparam int H = DW / 2, STR = P + 1, WORDS = N * STR;
  localparam int SW = $clog2(N), PW = $clog2(P);
`ifdef SCAN_SEQ_SKIP_INVALID_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic step_mode = 1'b0, beam_busy = 1'b0;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data = '0;
  logic beam_start, use_bi, busy, scan_done, run_done;
  logic [H-1:0] beam_magnitude, beam_angle, sensor_x, sensor_y;
  logic [SW-1:0] scan_index;
  logic [PW-1:0] point_index;
`ifdef SCAN_SEQ_SKIP_INVALID_EN
  logic [15:0] skipped_count;
`endif

  scan_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .POINTS_PER_SCAN(P),
    .NUM_SCANS(N), .MEM_LATENCY(ML)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .step_mode(step_mode),
    .mem_address(mem_address), .mem_data(mem_data),
    .beam_start(beam_start), .beam_magnitude(beam_magnitude),
    .beam_angle(beam_angle), .sensor_x(sensor_x), .sensor_y(sensor_y),
    .beam_busy(beam_busy), .use_bresenham_indices(use_bi),
    .busy(busy), .scan_done(scan_done), .run_done(run_done),
    .scan_index(scan_index), .point_index(point_index)
`ifdef SCAN_SEQ_SKIP_INVALID_EN
    , .skipped_count(skipped_count)
`endif
  );

  always #5 clock = ~clock;

  // One-cycle registered scan memory.
  logic [DW-1:0] mem [WORDS];
  always @(posedge clock)
    mem_data <= (int'(mem_address) < WORDS) ? mem[int'(mem_address)] : '0;

  // Ray-caster: busy for 3 cycles, raised bdelay cycles after it sees start.
  int bz = 0, dl = 0, bdelay = 1;
  always @(posedge clock) begin
    if (reset) begin
      bz = 0; dl = 0; beam_busy <= 1'b0;
    end else if (dl > 0) begin
      dl--;
      if (dl == 0) begin beam_busy <= 1'b1; bz = 3; end
    end else if (bz > 0) begin
      bz--;
      if (bz == 0) beam_busy <= 1'b0;
    end else if (beam_start) begin
      if (bdelay <= 1) begin beam_busy <= 1'b1; bz = 3; end
      else dl = bdelay - 1;
    end
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] word;
    logic [DW-1:0] pose;
  } beam_t;

  beam_t exp_q[$];
  beam_t e;
  logic [DW-1:0] exp_pose [N];
  int exp_rem [N];
  int exp_skip;

  // Expected beams follow directly from memory contents and the skip rule.
  task automatic prepare(input int mode);
    scan_word_t w;
    pose_t ps;
    int cum [N];
    int r;
    exp_q.delete();
    exp_skip = 0;
    for (int s = 0; s < N; s++) begin
      ps.x = (mode == 1) ? H'($urandom) : H'(5 + 2 * s);
      ps.y = (mode == 1) ? H'($urandom) : H'(9 - 6 * s);
      mem[s * STR] = ps;
      exp_pose[s] = ps;
      for (int p = 0; p < P; p++) begin
        if (mode == 1) begin
          r = int'($urandom_range(0, 7));
          w.magnitude = (r == 0) ? '0 : (r == 1) ? '1 : H'($urandom);
          w.angle = H'($urandom);
        end else begin
          w.magnitude = H'(100 + p + 10 * s);
          w.angle = H'(p + 1);
        end
        if (mode == 2 && s == 0 && p == 2) w.magnitude = '0;
        mem[s * STR + 1 + p] = w;
        if (SKIP_EN && (w.magnitude == '0 || w.magnitude == '1))
          exp_skip++;
        else
          exp_q.push_back('{word: w, pose: ps});
      end
      cum[s] = exp_q.size();
    end
    for (int s = 0; s < N; s++) exp_rem[s] = exp_q.size() - cum[s];
  endtask

  int sd_cnt = 0, rd_cnt = 0, sd_run = 0, hold = 0;
  bit bs_q = 1'b0, mon_on = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      bs_q = 1'b0; hold = 0;
    end else if (mon_on) begin
      if (beam_start) hold++;
      if (beam_start && !bs_q) begin
        chk("beam_avail", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beam_word", {beam_magnitude, beam_angle}, e.word);
          chk("beam_pose", {sensor_x, sensor_y}, e.pose);
        end
      end
      if (!beam_start && bs_q) begin
        chk("beam_hold", 64'(hold), 64'(bdelay + 1));
        hold = 0;
      end
      bs_q = beam_start;
      if (scan_done) begin
        if (sd_run < N) begin
          chk("scan_pose", {sensor_x, sensor_y}, exp_pose[sd_run]);
          chk("scan_rem", 64'(exp_q.size()), 64'(exp_rem[sd_run]));
        end
        chk("scan_idx", 64'(scan_index), 64'(sd_run));
        sd_run++;
        sd_cnt++;
      end
      if (run_done) rd_cnt++;
      if (busy) chk("addr_range", 64'(int'(mem_address) < WORDS), 64'd1);
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, 64'(mem_address), 64'd0);
    chk({tag, "_idx"}, 64'({scan_index, point_index}), 64'd0);
    chk({tag, "_ctl"},
        64'({beam_start, use_bi, busy, scan_done, run_done}), 64'd0);
    chk({tag, "_sensor"}, {sensor_x, sensor_y}, 64'd0);
    chk({tag, "_beam"}, {beam_magnitude, beam_angle}, 64'd0);
`ifdef SCAN_SEQ_SKIP_INVALID_EN
    chk({tag, "_skip"}, 64'(skipped_count), 64'd0);
`endif
  endtask

  // poke: 0 none, 1 start during WAIT_BEAM, 2 reset during WAIT_BEAM
  task automatic do_run(input bit step, input int poke);
    bit done, poked;
    int sd0, rd0;
    logic [63:0] snap;
    done = 1'b0; poked = 1'b0;
    sd0 = sd_cnt; rd0 = rd_cnt;
    sd_run = 0; mon_on = 1'b1; step_mode = step;
    start = 1'b1; @(negedge clock); start = 1'b0;
    chk("start_addr", 64'(mem_address), 64'd0);
    chk("start_busy", 64'(busy), 64'd1);
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clock);
      if (run_done) begin
        done = 1'b1;
      end else if (step && scan_done) begin
        @(negedge clock);
        for (int k = 0; k < 10; k++) begin
          chk("pause_busy", 64'(busy), 64'd1);
          chk("pause_addr", 64'(mem_address), 64'(sd_run * STR));
          chk("pause_cast", 64'({beam_start, use_bi}), 64'd0);
          @(negedge clock);
        end
        start = 1'b1; @(negedge clock); start = 1'b0;
      end else if (poke != 0 && !poked && busy && beam_busy &&
                   !beam_start && point_index == PW'(2)) begin
        poked = 1'b1;
        if (poke == 1) begin
          snap = 64'({mem_address, scan_index, point_index});
          start = 1'b1; @(negedge clock); start = 1'b0;
          chk("ignore_start",
              64'({mem_address, scan_index, point_index}), snap);
          chk("ignore_bs", 64'({beam_start, busy}), 64'b01);
        end else begin
          reset = 1'b1; @(negedge clock);
          check_zero("abort");
          reset = 1'b0;
          exp_q.delete();
          done = 1'b1;
        end
      end
    end
    chk("run_end", 64'(done), 64'd1);
    repeat (3) @(negedge clock);
    if (poke == 2) begin
      chk("abort_scan_done", 64'(sd_cnt - sd0), 64'd0);
      chk("abort_run_done", 64'(rd_cnt - rd0), 64'd0);
    end else begin
      chk("run_done_cnt", 64'(rd_cnt - rd0), 64'd1);
      chk("scan_done_cnt", 64'(sd_cnt - sd0), 64'(N));
      chk("beams_left", 64'(exp_q.size()), 64'd0);
      chk("end_addr", 64'(mem_address), 64'd0);
      chk("end_ctl", 64'({busy, use_bi, beam_start}), 64'd0);
      chk("end_pose", {sensor_x, sensor_y}, exp_pose[N-1]);
`ifdef SCAN_SEQ_SKIP_INVALID_EN
      chk("skipped", 64'(skipped_count), 64'(exp_skip));
`endif
    end
    mon_on = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clock);
    prepare(0); do_run(1'b0, 0);
    bdelay = 4;
    prepare(1); do_run(1'b0, 0);
    bdelay = 1;
    prepare(1); do_run(1'b1, 0);
    prepare(0); do_run(1'b0, 2);
    prepare(0); do_run(1'b0, 0);
    prepare(1); do_run(1'b0, 1);
    prepare(2); do_run(1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      bdelay = int'($urandom_range(1, 3));
      prepare(1);
      do_run(1'($urandom_range(0, 1)), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
